// File: rtl/id_ex_operand_stage_if.sv
// ID -> EX operand-stage bundle: decoded sources, forwarding sources and the registered EX view.
// valid_ID qualifies the ID fields; stall_ID is the back-pressure: while it is high ID must hold its instruction.
interface id_ex_operand_stage_if #(
  parameter int DW = 16,
  parameter int CW = 16
);
  logic          valid_ID;
  logic [3:0]    rdReg1_ID;
  logic [3:0]    rdReg2_ID;
  logic          rdEn1_ID;
  logic          rdEn2_ID;
  logic [1:0]    reg1_fwdCtrl;
  logic [1:0]    reg2_fwdCtrl;
  logic [DW-1:0] rfData1_ID;
  logic [DW-1:0] rfData2_ID;
  logic [3:0]    wrReg_ID;
  logic          wrEn_ID;
  logic          memRd_ID;
  logic [DW-1:0] result_EX;
  logic [DW-1:0] result_MEM;
  logic [DW-1:0] result_WB;
  logic          flush;
  logic          stall_in;
  logic [DW-1:0] opA_EX;
  logic [DW-1:0] opB_EX;
  logic [3:0]    wrReg_EX;
  logic          wrEn_EX;
  logic          memRd_EX;
  logic          valid_EX;
  logic          stall_ID;
  logic [CW-1:0] luStallCnt;

  modport master (
    output valid_ID, rdReg1_ID, rdReg2_ID, rdEn1_ID, rdEn2_ID, reg1_fwdCtrl, reg2_fwdCtrl,
           rfData1_ID, rfData2_ID, wrReg_ID, wrEn_ID, memRd_ID, result_EX, result_MEM,
           result_WB, flush, stall_in,
    input  opA_EX, opB_EX, wrReg_EX, wrEn_EX, memRd_EX, valid_EX, stall_ID, luStallCnt
  );

  modport slave (
    input  valid_ID, rdReg1_ID, rdReg2_ID, rdEn1_ID, rdEn2_ID, reg1_fwdCtrl, reg2_fwdCtrl,
           rfData1_ID, rfData2_ID, wrReg_ID, wrEn_ID, memRd_ID, result_EX, result_MEM,
           result_WB, flush, stall_in,
    output opA_EX, opB_EX, wrReg_EX, wrEn_EX, memRd_EX, valid_EX, stall_ID, luStallCnt
  );
endinterface

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with operand forwarding muxes and a one-bubble load-use interlock.
// fsm_state exposes the RUN(0)/BUBBLE(1) interlock state for observation.
module id_ex_operand_stage #(
  parameter int DW = 16,
  parameter int CW = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  id_ex_operand_stage_if.slave   bus,
  output logic                   fsm_state
);
  localparam logic [1:0] NO_FWD       = 2'b00;
  localparam logic [1:0] FWD_FROM_EX  = 2'b01;
  localparam logic [1:0] FWD_FROM_MEM = 2'b10;
  localparam logic [1:0] FWD_FROM_WB  = 2'b11;

  typedef enum logic {RUN = 1'b0, BUBBLE = 1'b1} state_t;
  state_t state;

  logic [DW-1:0] op_a;
  logic [DW-1:0] op_b;
  logic          dep1;
  logic          dep2;
  logic          lu;

  // r0 is hardwired to zero, so its forwarding code is ignored.
  function automatic logic [DW-1:0] pick(input logic [3:0] id, input logic [1:0] code,
                                         input logic [DW-1:0] rf, input logic [DW-1:0] ex,
                                         input logic [DW-1:0] mem, input logic [DW-1:0] wb);
    logic [DW-1:0] v;
    v = rf;
    case (code)
      FWD_FROM_EX:  v = ex;
      FWD_FROM_MEM: v = mem;
      FWD_FROM_WB:  v = wb;
      NO_FWD:       v = rf;
    endcase
    if (id == 4'd0) v = '0;
    return v;
  endfunction

  always_comb begin
    op_a = pick(bus.rdReg1_ID, bus.reg1_fwdCtrl, bus.rfData1_ID,
                bus.result_EX, bus.result_MEM, bus.result_WB);
    op_b = pick(bus.rdReg2_ID, bus.reg2_fwdCtrl, bus.rfData2_ID,
                bus.result_EX, bus.result_MEM, bus.result_WB);
    dep1 = bus.rdEn1_ID & (bus.rdReg1_ID != 4'd0) & (bus.reg1_fwdCtrl == FWD_FROM_EX);
    dep2 = bus.rdEn2_ID & (bus.rdReg2_ID != 4'd0) & (bus.reg2_fwdCtrl == FWD_FROM_EX);
    lu   = rst_n & bus.valid_EX & bus.memRd_EX & bus.valid_ID & (dep1 | dep2);
  end

  assign bus.stall_ID = rst_n & (lu | bus.stall_in) & ~bus.flush;
  assign fsm_state    = state;

  // A load-use bubble is needed only once: the next cycle the load sits in MEM and forwards from there.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.opA_EX     <= '0;
      bus.opB_EX     <= '0;
      bus.wrReg_EX   <= '0;
      bus.wrEn_EX    <= 1'b0;
      bus.memRd_EX   <= 1'b0;
      bus.valid_EX   <= 1'b0;
      bus.luStallCnt <= '0;
      state          <= RUN;
    end else if (bus.flush) begin
      bus.valid_EX <= 1'b0;
      bus.wrEn_EX  <= 1'b0;
      bus.memRd_EX <= 1'b0;
      state        <= RUN;
    end else if (bus.stall_in) begin
      state <= state;
    end else if (lu) begin
      bus.valid_EX <= 1'b0;
      bus.wrEn_EX  <= 1'b0;
      bus.memRd_EX <= 1'b0;
      if (~&bus.luStallCnt) bus.luStallCnt <= bus.luStallCnt + 1'b1;
      state <= BUBBLE;
    end else begin
      bus.opA_EX   <= op_a;
      bus.opB_EX   <= op_b;
      bus.wrReg_EX <= bus.wrReg_ID;
      bus.valid_EX <= bus.valid_ID;
      bus.wrEn_EX  <= bus.wrEn_ID & bus.valid_ID;
      bus.memRd_EX <= bus.memRd_ID & bus.valid_ID;
      state        <= RUN;
    end
  end
endmodule

// File: doc/id_ex_operand_stage.md
# id_ex_operand_stage

ID/EX pipeline register with operand forwarding muxes and load-use interlock. Consumes per-operand forwarding codes from the ID-stage hazard detector, selects each source operand from the register file or the EX/MEM/WB results, and registers the operands plus destination info into EX. Inserts a one-cycle bubble and stalls IF/ID when a source depends on a load still in EX. Its registered `wrReg_EX`/`wrEn_EX` feed back to the hazard detector.

## Interface
- `DW`, 16, datapath width of operands and results
- `CW`, 16, width of saturating load-use stall counter

- `clk`  in  1  clock, all state on rising edge
- `rst_n`  in  1  synchronous, active-low reset
- `valid_ID`  in  1  ID holds a real instruction
- `rdReg1_ID`, `rdReg2_ID`  in  4  source register ids
- `rdEn1_ID`, `rdEn2_ID`  in  1  source actually read
- `reg1_fwdCtrl`, `reg2_fwdCtrl`  in  2  forwarding codes, `FWD_FROM_EX`/`FWD_FROM_MEM`/`FWD_FROM_WB`/`NO_FWD` from defines.v
- `rfData1_ID`, `rfData2_ID`  in  DW  register file read data
- `wrReg_ID`  in  4  destination id
- `wrEn_ID`, `memRd_ID`  in  1  writes a register / is a load
- `result_EX`, `result_MEM`, `result_WB`  in  DW  forwarding sources (MEM value already includes load data)
- `flush`  in  1  kill instruction entering EX (branch redirect)
- `stall_in`  in  1  downstream hold of EX
- `opA_EX`, `opB_EX`  out  DW  registered operands
- `wrReg_EX`  out  4  registered destination id
- `wrEn_EX`, `memRd_EX`, `valid_EX`  out  1  registered controls
- `stall_ID`  out  1  hold PC and IF/ID this cycle
- `luStallCnt`  out  CW  count of load-use bubbles, saturating

## Operation
- Operand select, per source n: `rdRegn_ID == 0` -> 0 (r0 hardwired, code ignored); else code EX -> `result_EX`, MEM -> `result_MEM`, WB -> `result_WB`, any other -> `rfDatan_ID`.
- Load-use hazard `lu` = `valid_EX & memRd_EX & valid_ID` & (for either n: `rdEnn_ID` & `rdRegn_ID != 0` & code == `FWD_FROM_EX`).
- `stall_ID = (lu | stall_in) & ~flush`; combinational, same cycle.
- Two-state FSM, RUN/BUBBLE. RUN: `lu` & ~`stall_in` & ~`flush` -> BUBBLE. BUBBLE: one cycle, return to RUN; the dependency then arrives with code MEM, which is never stalled.
- Register update priority each edge:
  1. `~rst_n`: all EX outputs 0, FSM RUN, `luStallCnt` 0.
  2. `flush`: `valid_EX`, `wrEn_EX`, `memRd_EX` <= 0; operands/`wrReg_EX` don't-care (held); FSM RUN.
  3. `stall_in`: hold every EX register; FSM and counter hold.
  4. `lu`: bubble: `valid_EX`/`wrEn_EX`/`memRd_EX` <= 0; counter +1 unless all ones.
  5. else load: operands, `wrReg_EX`, `valid_EX <= valid_ID`, `wrEn_EX <= wrEn_ID & valid_ID`, `memRd_EX <= memRd_ID & valid_ID`.
- Invalid `valid_ID` never causes `lu` or counter change.
- Counter saturates at 2^CW-1; never wraps.

## Timing
- Reset values: `opA_EX`, `opB_EX`, `wrReg_EX`, `wrEn_EX`, `memRd_EX`, `valid_EX`, `luStallCnt` all 0; `stall_ID` 0 while `rst_n` low.
- Latency: ID inputs appear on EX outputs 1 cycle later.
- Load-use: exactly 1 bubble cycle per dependent instruction; dependent instruction enters EX 2 cycles after load entered EX.
- `flush` and `lu` same cycle: flush wins, `stall_ID` 0, no count.
- `stall_in` and `lu` same cycle: hold, no bubble inserted yet, no count; `lu` re-evaluated next cycle.
- Reset mid-BUBBLE: FSM returns to RUN, no pending stall.

## Test plan
- Reset with all inputs nonzero -> every output 0 next edge and while `rst_n` low.
- `rdReg1_ID=3`, code `FWD_FROM_MEM`, `result_MEM=16'h1234`, `rfData1_ID=16'hFFFF` -> `opA_EX=16'h1234` after 1 cycle; repeat for EX, WB, NO_FWD (rf data).
- `rdReg2_ID=0`, code `FWD_FROM_EX`, `result_EX=16'hBEEF` -> `opB_EX=0`, no stall even if EX is a load.
- Load r5 in EX, ID reads r5 with code `FWD_FROM_EX` -> `stall_ID=1` one cycle, `valid_EX=0` next edge, `luStallCnt=1`; next cycle code MEM -> `opA_EX=result_MEM`, `valid_EX=1`.
- Load-use coincident with `flush=1` -> `stall_ID=0`, `valid_EX=0`, count unchanged; coincident with `stall_in=1` -> EX regs held, bubble on the first cycle `stall_in` drops.
- Force counter to 2^CW-1, trigger load-use -> count stays 2^CW-1.
